// File: rtl/frv_mem_responder_if.sv
// Split-transaction memory bus between an initiator (req/gnt request phase,
// recv/ack response phase) and frv_mem_responder.
interface frv_mem_responder_if;
   logic        mem_req;
   logic        mem_wen;
   logic [3:0]  mem_strb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_recv;
   logic        mem_ack;
   logic        mem_error;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
      input  mem_gnt, mem_recv, mem_error, mem_rdata
   );

   modport slave (
      input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
      output mem_gnt, mem_recv, mem_error, mem_rdata
   );
endinterface

// File: rtl/frv_mem_responder.sv
// Word-addressed RAM behind an in-order response FIFO with programmable head latency.
// Define FRV_MEMRSP_RAND_STALL_EN to add LFSR-driven random grant/response stalls.
module frv_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          MEM_WORDS   = 1024,
   parameter int          OUTSTANDING = 4,
   parameter int          LATENCY     = 1
) (
   input  logic                i_clock,
   input  logic                i_reset,
   frv_mem_responder_if.slave  mem
);
   localparam int         AW  = $clog2(MEM_WORDS);
   localparam int         PW  = $clog2(OUTSTANDING);
   localparam logic [3:0] LAT = 4'(LATENCY);

   logic [31:0]   r_mem    [MEM_WORDS];
   logic          r_err_q  [OUTSTANDING];
   logic [31:0]   r_data_q [OUTSTANDING];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   logic [3:0]    r_wait;
   logic          r_ready;

   logic [31:0]   w_off;
   logic [AW-1:0] w_idx;
   logic          w_err;
   logic          w_full;
   logic          w_empty;
   logic          w_head_due;
   logic          w_gnt;
   logic          w_recv;
   logic          w_push;
   logic          w_pop;

   // Address decode; the index compare uses the full offset so addresses
   // below BASE_ADDR (which wrap to huge offsets) also land out of range.
   assign w_off   = mem.mem_addr - BASE_ADDR;
   assign w_idx   = w_off[AW+1:2];
   assign w_err   = (mem.mem_addr[1:0] != 2'b00) || (mem.mem_addr < BASE_ADDR) ||
                    ({2'b00, w_off[31:2]} >= 32'(MEM_WORDS));

   // Count can reach OUTSTANDING exactly, which is the only value with the MSB set.
   assign w_full     = r_count[PW];
   assign w_empty    = (r_count == '0);
   assign w_head_due = !w_empty && (r_wait == LAT);

`ifdef FRV_MEMRSP_RAND_STALL_EN
   logic [15:0] r_lfsr;
   logic        r_shown;
   logic        w_fb;

   assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_gnt  = r_ready && !w_full && (r_lfsr[1:0] != 2'b00);
   // Once presented, a response stays up until acked regardless of the LFSR.
   assign w_recv = w_head_due && (r_shown || (r_lfsr[3:2] != 2'b00));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_lfsr  <= 16'hACE1;
         r_shown <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
         if (w_pop)       r_shown <= 1'b0;
         else if (w_recv) r_shown <= 1'b1;
      end
   end
`else
   assign w_gnt  = r_ready && !w_full;
   assign w_recv = w_head_due;
`endif

   assign w_push = mem.mem_req && w_gnt;
   assign w_pop  = w_recv && mem.mem_ack;

   assign mem.mem_gnt   = w_gnt;
   assign mem.mem_recv  = w_recv;
   assign mem.mem_error = w_recv && r_err_q[r_rptr];
   assign mem.mem_rdata = w_recv ? r_data_q[r_rptr] : 32'h0;

   // r_ready keeps gnt low until the first edge after reset release.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_ready <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_wait  <= '0;
      end else begin
         r_ready <= 1'b1;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_pop)
            r_wait <= '0;
         else if (!w_empty && (r_wait != LAT))
            r_wait <= r_wait + 4'd1;
      end
   end

   // RAM and FIFO payload carry no reset; read data is captured at acceptance
   // so later writes cannot leak into an older read response.
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_err_q[r_wptr]  <= w_err;
         r_data_q[r_wptr] <= (!w_err && !mem.mem_wen) ? r_mem[w_idx] : 32'h0;
         if (!w_err && mem.mem_wen) begin
            for (int b = 0; b < 4; b++)
               if (mem.mem_strb[b]) r_mem[w_idx][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_frv_mem_responder.sv
// Randomized self-checking bench for frv_mem_responder: two instances
// (LATENCY 1 and 0) checked against a queue-based transaction model.
module tb_frv_mem_responder;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          W    = 256;
   localparam int          OUT  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b0;
   logic        req = 1'b0, wen = 1'b0, ack = 1'b0;
   logic [3:0]  strb = 4'h0;
   logic [31:0] wdata = 32'h0, addr = 32'h0;

   always #5 clk = ~clk;

   frv_mem_responder_if if0 ();
   frv_mem_responder_if if1 ();

   assign if0.mem_req   = req & ~sel;
   assign if0.mem_ack   = ack & ~sel;
   assign if0.mem_wen   = wen;
   assign if0.mem_strb  = strb;
   assign if0.mem_wdata = wdata;
   assign if0.mem_addr  = addr;
   assign if1.mem_req   = req & sel;
   assign if1.mem_ack   = ack & sel;
   assign if1.mem_wen   = wen;
   assign if1.mem_strb  = strb;
   assign if1.mem_wdata = wdata;
   assign if1.mem_addr  = addr;

   frv_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(W), .OUTSTANDING(OUT), .LATENCY(1)) u_lat1 (
      .i_clock(clk), .i_reset(rst), .mem(if0.slave));
   frv_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(W), .OUTSTANDING(OUT), .LATENCY(0)) u_lat0 (
      .i_clock(clk), .i_reset(rst), .mem(if1.slave));

   typedef struct {
      bit          err;
      logic [31:0] data;
      int          acc;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mm [2][W];
   int          pop_lat[$];
   int          pop_cyc[$];
   logic [31:0] pop_data[$];
   logic        pop_err[$];
   int          cyc = 0, last_pop = -100, n_chk = 0, n_fail = 0, n_acc = 0, n_pop = 0;
   bit          live = 0, t_acc = 0;
   logic        o_g, o_rv, o_e;
   logic [31:0] o_d;

   // One bus cycle: compare outputs against the model, account for the
   // handshakes that complete at the next rising edge, then advance.
   task automatic tick();
      int          lat = sel ? 0 : 1;
      bit          eg, erv;
      int          hd;
      ent_t        e;
      logic [31:0] off;
      int          ix;
      o_g  = sel ? if1.mem_gnt   : if0.mem_gnt;
      o_rv = sel ? if1.mem_recv  : if0.mem_recv;
      o_e  = sel ? if1.mem_error : if0.mem_error;
      o_d  = sel ? if1.mem_rdata : if0.mem_rdata;
      eg  = live && (q.size() < OUT);
      erv = 0;
      if (q.size() > 0) begin
         hd  = ((q[0].acc > last_pop) ? q[0].acc : last_pop) + 1 + lat;
         erv = (cyc >= hd);
      end
      n_chk++;
      if (o_g !== eg) begin n_fail++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, o_g, eg); end
      n_chk++;
      if (o_rv !== erv) begin n_fail++; $display("FAIL recv cyc=%0d got=%b exp=%b", cyc, o_rv, erv); end
      if (o_rv === 1'b1 && erv) begin
         n_chk++;
         if ({o_e, o_d} !== {q[0].err, q[0].data}) begin
            n_fail++;
            $display("FAIL resp cyc=%0d got=%b/%h exp=%b/%h", cyc, o_e, o_d, q[0].err, q[0].data);
         end
      end else if (o_rv === 1'b0) begin
         n_chk++;
         if (o_e !== 1'b0 || o_d !== 32'h0) begin
            n_fail++; $display("FAIL idle_out cyc=%0d got=%b/%h exp=0/0", cyc, o_e, o_d);
         end
      end
      t_acc = req && (o_g === 1'b1);
      if (o_rv === 1'b1 && ack && q.size() > 0) begin
         e = q.pop_front();
         pop_lat.push_back(cyc - e.acc);
         pop_cyc.push_back(cyc);
         pop_data.push_back(o_d);
         pop_err.push_back(o_e);
         last_pop = cyc;
         n_pop++;
      end
      if (t_acc) begin
         off   = addr - BASE;
         e.err = (addr[1:0] != 2'b00) || (addr < BASE) || ((off >> 2) >= 32'(W));
         e.data = 32'h0;
         e.acc  = cyc;
         if (!e.err) begin
            ix = int'(off >> 2);
            if (wen) begin
               for (int b = 0; b < 4; b++)
                  if (strb[b]) mm[sel][ix][8*b +: 8] = wdata[8*b +: 8];
            end else e.data = mm[sel][ix];
         end
         q.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      if (!rst) live = 1;
      @(negedge clk);
      cyc++;
   endtask

   task automatic pop_clear();
      pop_lat.delete(); pop_cyc.delete(); pop_data.delete(); pop_err.delete();
   endtask

   task automatic issue(input bit w, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a);
      int n = 0;
      req = 1; wen = w; strb = s; wdata = d; addr = a;
      do begin tick(); n++; end while (!t_acc && n < 50);
      req = 0;
      n_chk++;
      if (!t_acc) begin n_fail++; $display("FAIL issue_timeout addr=%h got=no_grant exp=grant", a); end
   endtask

   task automatic drain();
      int n = 0;
      ack = 1; req = 0;
      while (q.size() > 0 && n < 60) begin tick(); n++; end
      tick();
      n_chk++;
      if (q.size() != 0) begin n_fail++; $display("FAIL drain_timeout got=%0d exp=0", q.size()); end
   endtask

   task automatic apply_reset();
      req = 0; ack = 0; rst = 1;
      q.delete(); live = 0; last_pop = -100;
      #1;
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_chk++;
      if ({if0.mem_gnt, if0.mem_recv, if0.mem_error, if0.mem_rdata} !== 35'h0) begin
         n_fail++; $display("FAIL reset_out0 got=%b%b%b/%h exp=0", if0.mem_gnt, if0.mem_recv, if0.mem_error, if0.mem_rdata);
      end
      n_chk++;
      if ({if1.mem_gnt, if1.mem_recv} !== 2'b00) begin
         n_fail++; $display("FAIL reset_out1 got=%b%b exp=00", if1.mem_gnt, if1.mem_recv);
      end
      release_reset();
      tick();
      n_chk++;
      if (if0.mem_gnt !== 1'b1) begin n_fail++; $display("FAIL gnt_after_reset got=%b exp=1", if0.mem_gnt); end
   endtask

   task automatic test_basic_rw();
      pop_clear(); ack = 1;
      issue(1, 4'hF, 32'hDEADBEEF, BASE + 32'h10);
      drain();
      issue(0, 4'h0, 32'h0, BASE + 32'h10);
      drain();
      n_chk++;
      if (pop_data.size() != 2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", pop_data.size()); end
      else begin
         n_chk++;
         if ({pop_err[0], pop_data[0]} !== 33'h0) begin
            n_fail++; $display("FAIL basic_wr_resp got=%b/%h exp=0/0", pop_err[0], pop_data[0]);
         end
         n_chk++;
         if ({pop_err[1], pop_data[1]} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL basic_rd_resp got=%b/%h exp=0/deadbeef", pop_err[1], pop_data[1]);
         end
         n_chk++;
         if (pop_lat[0] != 2 || pop_lat[1] != 2) begin
            n_fail++; $display("FAIL basic_latency got=%0d,%0d exp=2,2", pop_lat[0], pop_lat[1]);
         end
      end
   endtask

   task automatic test_strobes();
      pop_clear(); ack = 1;
      issue(1, 4'hF,    32'h11223344, BASE + 32'h20);
      issue(1, 4'b0101, 32'hAABBCCDD, BASE + 32'h20);
      issue(0, 4'h0,    32'h0,        BASE + 32'h20);
      drain();
      n_chk++;
      if (pop_data.size() != 3 || pop_data[2] !== 32'h11BB33DD) begin
         n_fail++; $display("FAIL strobe_merge got=%h exp=11bb33dd", (pop_data.size() == 3) ? pop_data[2] : 32'hX);
      end
   endtask

   task automatic test_errors();
      pop_clear(); ack = 1;
      issue(0, 4'h0, 32'h0, BASE + 32'h22);
      issue(0, 4'h0, 32'h0, BASE + 32'(4 * W));
      issue(0, 4'h0, 32'h0, BASE - 32'h4);
      issue(1, 4'hF, 32'hFFFFFFFF, BASE + 32'h22);
      issue(0, 4'h0, 32'h0, BASE + 32'h20);
      drain();
      n_chk++;
      if (pop_data.size() != 5) begin n_fail++; $display("FAIL err_count got=%0d exp=5", pop_data.size()); end
      else begin
         for (int k = 0; k < 4; k++) begin
            n_chk++;
            if ({pop_err[k], pop_data[k]} !== {1'b1, 32'h0}) begin
               n_fail++; $display("FAIL err_resp%0d got=%b/%h exp=1/0", k, pop_err[k], pop_data[k]);
            end
         end
         n_chk++;
         if ({pop_err[4], pop_data[4]} !== {1'b0, 32'h11BB33DD}) begin
            n_fail++; $display("FAIL err_ram_intact got=%b/%h exp=0/11bb33dd", pop_err[4], pop_data[4]);
         end
      end
   endtask

   task automatic test_backpressure();
      int          k = 0, grants = 0, gcyc = -1, n = 0;
      bit          snap_ok = 0;
      logic [32:0] snap;
      ack = 1;
      for (int i = 0; i < 6; i++) issue(1, 4'hF, 32'h100 + i, BASE + 32'(4 * (40 + i)));
      drain();
      pop_clear(); ack = 0;
      req = 1; wen = 0; addr = BASE + 32'(4 * 40);
      for (int c = 0; c < 10; c++) begin
         tick();
         if (o_rv === 1'b1) begin
            if (!snap_ok) begin snap = {o_e, o_d}; snap_ok = 1; end
            else begin
               n_chk++;
               if ({o_e, o_d} !== snap) begin n_fail++; $display("FAIL bp_stable got=%h exp=%h", {o_e, o_d}, snap); end
            end
         end
         if (t_acc) begin grants++; k++; addr = BASE + 32'(4 * (40 + k)); end
      end
      n_chk++;
      if (grants != 4 || o_g !== 1'b0) begin
         n_fail++; $display("FAIL bp_grants got=%0d/gnt=%b exp=4/gnt=0", grants, o_g);
      end
      ack = 1;
      while (k < 6 && n < 40) begin
         tick(); n++;
         if (t_acc) begin
            if (gcyc < 0) gcyc = cyc - 1;
            k++; addr = BASE + 32'(4 * (40 + k));
            if (k == 6) req = 0;
         end
      end
      req = 0;
      drain();
      n_chk++;
      if (pop_cyc.size() == 0 || gcyc != pop_cyc[0] + 1) begin
         n_fail++; $display("FAIL bp_regrant got=%0d exp=%0d", gcyc, (pop_cyc.size() > 0) ? pop_cyc[0] + 1 : -1);
      end
      n_chk++;
      if (pop_data.size() != 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", pop_data.size()); end
      else
         for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (pop_data[i] !== 32'h100 + i) begin
               n_fail++; $display("FAIL bp_order%0d got=%h exp=%h", i, pop_data[i], 32'h100 + i);
            end
         end
   endtask

   task automatic test_raw_lat0();
      apply_reset(); sel = 1; release_reset(); tick();
      ack = 1;
      issue(1, 4'hF, 32'h5, BASE + 32'h80);
      drain();
      pop_clear();
      req = 1; wen = 0; strb = 4'h0; addr = BASE + 32'h80;
      tick();
      n_chk++;
      if (!t_acc) begin n_fail++; $display("FAIL raw_rd_grant got=0 exp=1"); end
      wen = 1; strb = 4'hF; wdata = 32'h9;
      tick();
      n_chk++;
      if (!t_acc) begin n_fail++; $display("FAIL raw_wr_grant got=0 exp=1"); end
      req = 0;
      drain();
      issue(0, 4'h0, 32'h0, BASE + 32'h80);
      drain();
      n_chk++;
      if (pop_data.size() != 3) begin n_fail++; $display("FAIL raw_count got=%0d exp=3", pop_data.size()); end
      else begin
         n_chk++;
         if (pop_data[0] !== 32'h5 || pop_lat[0] != 1) begin
            n_fail++; $display("FAIL raw_old_data got=%h/lat%0d exp=5/lat1", pop_data[0], pop_lat[0]);
         end
         n_chk++;
         if (pop_cyc[1] != pop_cyc[0] + 1) begin
            n_fail++; $display("FAIL raw_b2b got=%0d exp=%0d", pop_cyc[1], pop_cyc[0] + 1);
         end
         n_chk++;
         if (pop_data[2] !== 32'h9) begin n_fail++; $display("FAIL raw_new_data got=%h exp=9", pop_data[2]); end
      end
   endtask

   task automatic test_reset_mid();
      ack = 1;
      issue(1, 4'hF, 32'h77, BASE + 32'h84);
      drain();
      ack = 0;
      for (int i = 0; i < 3; i++) issue(0, 4'h0, 32'h0, BASE + 32'h84);
      tick(); tick();
      n_chk++;
      if (o_rv !== 1'b1) begin n_fail++; $display("FAIL mid_pending got=%b exp=1", o_rv); end
      apply_reset();
      n_chk++;
      if ({if1.mem_recv, if1.mem_gnt} !== 2'b00) begin
         n_fail++; $display("FAIL mid_reset_out got=%b%b exp=00", if1.mem_recv, if1.mem_gnt);
      end
      release_reset();
      repeat (3) tick();
      pop_clear(); ack = 1;
      issue(0, 4'h0, 32'h0, BASE + 32'h84);
      drain();
      n_chk++;
      if (pop_data.size() != 1 || pop_data[0] !== 32'h77) begin
         n_fail++; $display("FAIL mid_ram_kept got=%h exp=77", (pop_data.size() > 0) ? pop_data[0] : 32'hX);
      end
   endtask

   task automatic test_random();
      int a0, p0;
      apply_reset(); sel = 0; release_reset(); tick();
      ack = 1;
      for (int i = 0; i < 16; i++) issue(1, 4'hF, $urandom, BASE + 32'h100 + 32'(4 * i));
      drain();
      a0 = n_acc; p0 = n_pop;
      for (int c = 0; c < 400; c++) begin
         if (!req && $urandom_range(0, 3) != 0) begin
            req = 1; wen = $urandom_range(0, 1); strb = 4'($urandom); wdata = $urandom;
            case ($urandom_range(0, 9))
               0:       addr = BASE + 32'h102;
               1:       addr = BASE + 32'(4 * W) + 32'(4 * $urandom_range(0, 3));
               2:       addr = BASE - 32'h4;
               default: addr = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15));
            endcase
         end
         ack = ($urandom_range(0, 2) != 0);
         tick();
         if (t_acc) req = 0;
      end
      req = 0;
      drain();
      n_chk++;
      if (n_acc - a0 != n_pop - p0) begin
         n_fail++; $display("FAIL rand_balance got=%0d exp=%0d", n_pop - p0, n_acc - a0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_strobes();
      test_errors();
      test_backpressure();
      test_raw_lat0();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/frv_mem_responder.md
Name: frv_mem_responder

Overview:
- Memory-side responder for the core's split-transaction memory interface: `req`/`gnt` request phase, `recv`/`ack` response phase.
- Contains a word-addressed backing RAM and an in-order response FIFO that allows several outstanding requests.
- Response latency is programmable.
- Serves as an imem or dmem responder in the simulation and formal environments around frv_core.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0 of the RAM.
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
- OUTSTANDING, 4, response FIFO depth; power of two, >=2.
- LATENCY, 1, extra cycles a FIFO head waits before `recv` asserts; 0..15.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  in  1  request valid; held by initiator until gnt.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  4  byte write strobes; ignored on reads.
- mem_wdata  in  32  write data.
- mem_addr  in  32  byte address.
- mem_gnt  out  1  request accepted this cycle when mem_req && mem_gnt.
- mem_recv  out  1  response valid.
- mem_ack  in  1  initiator consumes response when mem_recv && mem_ack.
- mem_error  out  1  response carries an error.
- mem_rdata  out  32  read data; 0 for writes and errors.

Behaviour:
- Reset (async assert, released synchronously to clock):
  - FIFO pointers, count, head wait counter and LFSR are cleared.
  - mem_gnt = 0 while reset is high, and rises the first cycle after reset is low.
  - mem_recv = 0, mem_error = 0, mem_rdata = 0.
  - RAM contents are not reset.
- Grant: mem_gnt = !fifo_full (ANDed with the stall term when the optional feature is enabled). Combinational from registered state only; no dependence on mem_req.
- Acceptance (mem_req && mem_gnt at a clock edge):
  - Word index = (mem_addr - BASE_ADDR) >> 2.
  - Error if mem_addr[1:0] != 0, if mem_addr < BASE_ADDR, or if index >= MEM_WORDS.
  - Write without error: RAM bytes updated per mem_strb at this edge. Strobe 4'b0000 is a legal no-op.
  - Read without error: the RAM word is sampled at this edge, so a later accepted write cannot alter the returned data.
  - One FIFO entry {error, rdata} is pushed. rdata is 0 for writes and for errors. On error, no RAM access is made.
- Response:
  - Entry becomes head, then the head wait counter counts up each cycle.
  - mem_recv = fifo_nonempty && (wait_cnt == LATENCY).
  - LATENCY = 0 gives recv the cycle after acceptance.
  - mem_error and mem_rdata are driven from the head entry while mem_recv = 1, and are 0 otherwise.
  - While mem_recv && !mem_ack, all response outputs are held stable.
  - On mem_recv && mem_ack, the entry is popped and wait_cnt resets to 0. The next entry may assert recv the following cycle if LATENCY = 0.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - When full, gnt = 0 even if a pop occurs in the same cycle (conservative).
  - Pointers wrap modulo OUTSTANDING.
- mem_ack without mem_recv is ignored.
- Reset mid-operation: all outstanding responses are dropped and recv falls immediately. Writes already accepted remain in RAM.
- Ordering: responses are strictly in acceptance order.

Optional Feature:
- Macro: FRV_MEMRSP_RAND_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - mem_gnt is additionally forced to 0 when lfsr[1:0] == 2'b00.
  - mem_recv is additionally suppressed while lfsr[3:2] == 2'b00 and the head is not yet presented. Once recv is asserted it is never withdrawn before ack.
- Undefined: no LFSR logic; grant and response behave exactly as above.

Test Plan:
- Reset, LATENCY = 1: write 32'hDEADBEEF to BASE+0x10 with strb 4'hF, then read BASE+0x10 -> write response recv=1 error=0 rdata=0; read response rdata=32'hDEADBEEF; each recv two cycles after its grant.
- Byte strobes: write 32'h11223344 with strb 4'hF, then write 32'hAABBCCDD with strb 4'b0101 to the same word, then read -> 32'h11BB33DD.
- Errors: reads to BASE+0x2 (misaligned), BASE+4*MEM_WORDS and BASE-4 -> error=1, rdata=0, RAM unchanged on a subsequent valid read.
- Backpressure: hold mem_ack = 0, issue 6 back-to-back reads with OUTSTANDING = 4 -> exactly 4 grants, then gnt = 0. Head outputs stay stable. Raising ack drains the FIFO in order and gnt returns the cycle after the first pop.
- Read-after-write ordering, LATENCY = 0: read A (old value 5), then write A=9 in the next cycle, with ack always high -> read returns 5, back-to-back recv on consecutive cycles.
- Reset asserted with 3 responses pending -> recv and gnt fall immediately. After release, FIFO is empty and a read of previously written data returns the written value.
